// File: rtl/oric_tape_encoder.sv
// Oric cassette encoder: frames a byte as 13 bits and emits HI(T)/LO(T or 2T) pulses.
// Tape goes high one cycle after the din handshake; din_ready is held low while a frame runs or en=0.
module oric_tape_encoder #(
  parameter int CLK_US  = 24,
  parameter int HALF_US = 208
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        en,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        tape,
  output logic        active,
  output logic [15:0] bytes_sent
);

  localparam int T  = CLK_US * HALF_US;
  localparam int CW = $clog2(2 * T + 1);
  localparam logic [CW-1:0] T_LAST  = CW'(T - 1);
  localparam logic [CW-1:0] T2_LAST = CW'(2 * T - 1);

  typedef enum logic [1:0] {IDLE, HI, LO} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [3:0]     idx, idx_nxt;
  logic [12:0]    frame, frame_nxt;
  logic           tape_nxt;
  logic [15:0]    sent_cnt, sent_nxt;
  logic [CW-1:0]  lo_last;

  assign din_ready  = (state == IDLE) && en;
  assign active     = (state != IDLE);
  assign bytes_sent = sent_cnt;
  // a 0 bit keeps the line low for twice as long as a 1 bit
  assign lo_last    = frame[idx] ? T_LAST : T2_LAST;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      frame    <= '0;
      tape     <= 1'b0;
      sent_cnt <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      frame    <= frame_nxt;
      tape     <= tape_nxt;
      sent_cnt <= sent_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    frame_nxt = frame;
    tape_nxt  = tape;
    sent_nxt  = sent_cnt;
    if (en) begin
      case (state)
        IDLE: begin
          if (din_valid) begin
            // stop bits, odd-inverted parity, data LSB first, start bit
            frame_nxt = {3'b111, ~^din, din, 1'b0};
            idx_nxt   = '0;
            cnt_nxt   = '0;
            tape_nxt  = 1'b1;
            state_nxt = HI;
          end
        end
        HI: begin
          if (cnt == T_LAST) begin
            cnt_nxt   = '0;
            tape_nxt  = 1'b0;
            state_nxt = LO;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        LO: begin
          if (cnt == lo_last) begin
            cnt_nxt = '0;
            if (idx == 4'd12) begin
              state_nxt = IDLE;
              sent_nxt  = sent_cnt + 16'd1;
            end else begin
              idx_nxt   = idx + 4'd1;
              tape_nxt  = 1'b1;
              state_nxt = HI;
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
